// File: rtl/fu_result_collector.sv
// Functional-unit result collector.
// Gathers the results of a dual-issue group (two ALUs plus an optional MUL and/or DIV)
// and presents them as a single writeback pair once every unit in the group has finished.
module fu_result_collector (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        issue_valid,
  input  logic [3:0]  FU_en,
  input  logic        FU_ctrl,
  input  logic        way0_valid,
  input  logic        way1_valid,
  input  logic [4:0]  way0_waddr,
  input  logic [4:0]  way1_waddr,
  input  logic [31:0] alu0_result,
  input  logic [31:0] alu1_result,
  input  logic        mul_valid,
  input  logic [63:0] mul_result,
  input  logic        div_valid,
  input  logic [63:0] div_result,
  output logic        wb0_valid,
  output logic        wb1_valid,
  output logic [4:0]  wb0_waddr,
  output logic [4:0]  wb1_waddr,
  output logic [31:0] wb0_data,
  output logic [31:0] wb1_data,
  output logic        wb0_hilo_we,
  output logic        wb1_hilo_we,
  output logic [63:0] wb0_hilo,
  output logic [63:0] wb1_hilo,
  output logic        stall_req,
  output logic        fu_en_err
);

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  state_t      state_q;
  logic [1:0]  pending_q;
  logic [1:0]  pending_d;
  logic [1:0]  aluEn_q;
  logic        ctrl_q;
  logic        way0Valid_q;
  logic        way1Valid_q;
  logic [4:0]  way0Waddr_q;
  logic [4:0]  way1Waddr_q;
  logic [31:0] alu0_q;
  logic [31:0] alu1_q;
  logic [63:0] mul_q;
  logic [63:0] div_q;
  logic        err_q;

  logic        fuEnLegal;
  logic [3:0]  effEn;
  logic        effCtrl;

  // Decode the unit-enable code; anything unrecognised falls back to a plain ALU pair.
  always_comb begin
    fuEnLegal = 1'b0;
    case (FU_en)
      4'b0011, 4'b0101, 4'b0110,
      4'b1001, 4'b1010, 4'b1100: fuEnLegal = 1'b1;
      default:                   fuEnLegal = 1'b0;
    endcase
    effEn   = fuEnLegal ? FU_en   : 4'b0011;
    effCtrl = fuEnLegal ? FU_ctrl : 1'b0;
  end

  // Completion pulses only retire a unit that the current group is still waiting on.
  always_comb begin
    pending_d = pending_q;
    if (mul_valid && pending_q[0]) pending_d[0] = 1'b0;
    if (div_valid && pending_q[1]) pending_d[1] = 1'b0;
  end

  // Collector FSM: latch the group on issue, wait for long-latency units, then emit one OUT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= 2'b00;
      aluEn_q     <= 2'b00;
      ctrl_q      <= 1'b0;
      way0Valid_q <= 1'b0;
      way1Valid_q <= 1'b0;
      way0Waddr_q <= 5'd0;
      way1Waddr_q <= 5'd0;
      alu0_q      <= 32'd0;
      alu1_q      <= 32'd0;
      mul_q       <= 64'd0;
      div_q       <= 64'd0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (flush) begin
        state_q   <= IDLE;
        pending_q <= 2'b00;
      end else begin
        case (state_q)
          IDLE: begin
            if (issue_valid) begin
              aluEn_q     <= effEn[1:0];
              ctrl_q      <= effCtrl;
              way0Valid_q <= way0_valid;
              way1Valid_q <= way1_valid;
              way0Waddr_q <= way0_waddr;
              way1Waddr_q <= way1_waddr;
              alu0_q      <= effEn[0] ? alu0_result : 32'd0;
              alu1_q      <= effEn[1] ? alu1_result : 32'd0;
              mul_q       <= 64'd0;
              div_q       <= 64'd0;
              pending_q   <= effEn[3:2];
              err_q       <= ~fuEnLegal;
              state_q     <= (effEn[3:2] == 2'b00) ? OUT : WAIT;
            end
          end
          WAIT: begin
            if (mul_valid && pending_q[0]) mul_q <= mul_result;
            if (div_valid && pending_q[1]) div_q <= div_result;
            pending_q <= pending_d;
            if (pending_d == 2'b00) state_q <= OUT;
          end
          OUT: begin
            state_q <= IDLE;
          end
          default: begin
            state_q   <= IDLE;
            pending_q <= 2'b00;
          end
        endcase
      end
    end
  end

  // Writeback outputs are a pure function of the registered state and latched group.
  always_comb begin
    wb0_valid   = 1'b0;
    wb1_valid   = 1'b0;
    wb0_waddr   = 5'd0;
    wb1_waddr   = 5'd0;
    wb0_data    = 32'd0;
    wb1_data    = 32'd0;
    wb0_hilo_we = 1'b0;
    wb1_hilo_we = 1'b0;
    wb0_hilo    = 64'd0;
    wb1_hilo    = 64'd0;
    if (state_q == OUT) begin
      wb0_valid = way0Valid_q;
      wb1_valid = way1Valid_q;
      wb0_waddr = way0Waddr_q;
      wb1_waddr = way1Waddr_q;
      if (aluEn_q[0]) begin
        wb0_data = alu0_q;
      end else begin
        wb0_hilo    = ctrl_q ? div_q : mul_q;
        wb0_hilo_we = way0Valid_q;
      end
      if (aluEn_q[1]) begin
        wb1_data = alu1_q;
      end else begin
        wb1_hilo    = ctrl_q ? mul_q : div_q;
        wb1_hilo_we = way1Valid_q;
      end
    end
  end

  assign stall_req = (state_q != IDLE);
  assign fu_en_err = err_q;

endmodule

// File: tb/tb_fu_result_collector.sv
// Scoreboard testbench for fu_result_collector: directed groups push expected writebacks,
// an independent monitor pops and compares whenever the collector presents a writeback.
module tb_fu_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  FU_en;
  logic        FU_ctrl;
  logic        way0_valid, way1_valid;
  logic [4:0]  way0_waddr, way1_waddr;
  logic [31:0] alu0_result, alu1_result;
  logic        mul_valid, div_valid;
  logic [63:0] mul_result, div_result;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_waddr, wb1_waddr;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_hilo_we, wb1_hilo_we;
  logic [63:0] wb0_hilo, wb1_hilo;
  logic        stall_req;
  logic        fu_en_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic        v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        we0, we1;
    logic        chkH0, chkH1;
    logic [63:0] h0, h1;
  } exp_t;

  exp_t expQ[$];
  exp_t e;

  fu_result_collector dut (
    .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
    .FU_en(FU_en), .FU_ctrl(FU_ctrl),
    .way0_valid(way0_valid), .way1_valid(way1_valid),
    .way0_waddr(way0_waddr), .way1_waddr(way1_waddr),
    .alu0_result(alu0_result), .alu1_result(alu1_result),
    .mul_valid(mul_valid), .mul_result(mul_result),
    .div_valid(div_valid), .div_result(div_result),
    .wb0_valid(wb0_valid), .wb1_valid(wb1_valid),
    .wb0_waddr(wb0_waddr), .wb1_waddr(wb1_waddr),
    .wb0_data(wb0_data), .wb1_data(wb1_data),
    .wb0_hilo_we(wb0_hilo_we), .wb1_hilo_we(wb1_hilo_we),
    .wb0_hilo(wb0_hilo), .wb1_hilo(wb1_hilo),
    .stall_req(stall_req), .fu_en_err(fu_en_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    issue_valid = 1'b0;
    flush       = 1'b0;
    mul_valid   = 1'b0;
    div_valid   = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic ctrl,
                               input logic v0, input logic v1,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic [31:0] r0, input logic [31:0] r1);
    issue_valid = 1'b1;
    FU_en       = en;
    FU_ctrl     = ctrl;
    way0_valid  = v0;
    way1_valid  = v1;
    way0_waddr  = a0;
    way1_waddr  = a1;
    alu0_result = r0;
    alu1_result = r1;
  endtask

  task automatic pushExp(input int c, input logic v0, input logic v1,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic we0, input logic we1,
                         input logic ch0, input logic ch1,
                         input logic [63:0] h0, input logic [63:0] h1);
    exp_t x;
    x.cyc = c; x.v0 = v0; x.v1 = v1; x.a0 = a0; x.a1 = a1;
    x.d0 = d0; x.d1 = d1; x.we0 = we0; x.we1 = we1;
    x.chkH0 = ch0; x.chkH1 = ch1; x.h0 = h0; x.h1 = h1;
    expQ.push_back(x);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stall"}, {63'd0, stall_req}, 64'd0);
    checkOutput({tag, "_err"}, {63'd0, fu_en_err}, 64'd0);
    checkOutput({tag, "_strobes"}, {60'd0, wb0_valid, wb1_valid, wb0_hilo_we, wb1_hilo_we}, 64'd0);
    checkOutput({tag, "_data"}, {wb0_data, wb1_data}, 64'd0);
    checkOutput({tag, "_waddr"}, {54'd0, wb0_waddr, wb1_waddr}, 64'd0);
    checkOutput({tag, "_hilo"}, wb0_hilo | wb1_hilo, 64'd0);
  endtask

  // Monitor: any writeback strobe must match the oldest expected entry, including its cycle.
  always @(negedge clk) begin
    if (!reset && (wb0_valid || wb1_valid || wb0_hilo_we || wb1_hilo_we)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_wb", {60'd0, wb0_valid, wb1_valid, wb0_hilo_we, wb1_hilo_we}, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("wb_valid", {62'd0, wb0_valid, wb1_valid}, {62'd0, e.v0, e.v1});
        checkOutput("wb_waddr", {54'd0, wb0_waddr, wb1_waddr}, {54'd0, e.a0, e.a1});
        checkOutput("wb_data", {wb0_data, wb1_data}, {e.d0, e.d1});
        checkOutput("wb_hilo_we", {62'd0, wb0_hilo_we, wb1_hilo_we}, {62'd0, e.we0, e.we1});
        if (e.chkH0) checkOutput("wb0_hilo", wb0_hilo, e.h0);
        if (e.chkH1) checkOutput("wb1_hilo", wb1_hilo, e.h1);
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1;
    idleInputs();
    FU_en = 4'd0; FU_ctrl = 1'b0;
    way0_valid = 1'b0; way1_valid = 1'b0;
    way0_waddr = 5'd0; way1_waddr = 5'd0;
    alu0_result = 32'd0; alu1_result = 32'd0;
    mul_result = 64'd0; div_result = 64'd0;

    tick();
    tick();
    checkAllZero("reset");
    reset = 1'b0;
    tick();

    // ALU-only pair, writeback one cycle after issue
    k = cyc;
    applyStimulus(4'b0011, 1'b0, 1'b1, 1'b1, 5'd3, 5'd4, 32'h11, 32'h22);
    pushExp(k + 1, 1, 1, 5'd3, 5'd4, 32'h11, 32'h22, 0, 0, 0, 0, 64'd0, 64'd0);
    tick();
    idleInputs();
    checkOutput("alu_pair_stall", {63'd0, stall_req}, 64'd1);
    checkOutput("alu_pair_err", {63'd0, fu_en_err}, 64'd0);
    tick();
    checkOutput("alu_pair_stall_end", {63'd0, stall_req}, 64'd0);

    // MUL on way0 and DIV on way1; a stray MUL pulse and issue while waiting are ignored
    k = cyc;
    applyStimulus(4'b1100, 1'b0, 1'b1, 1'b1, 5'd5, 5'd6, 32'h77, 32'h88);
    pushExp(k + 6, 1, 1, 5'd5, 5'd6, 32'd0, 32'd0, 1, 1, 1, 1,
            64'h0000_00AA_0000_00BB, 64'h0000_0003_0000_0007);
    for (int i = 1; i <= 7; i++) begin
      tick();
      idleInputs();
      checkOutput($sformatf("muldiv_stall_%0d", i), {63'd0, stall_req}, (i <= 6) ? 64'd1 : 64'd0);
      if (i == 2) begin mul_valid = 1'b1; mul_result = 64'h0000_00AA_0000_00BB; end
      if (i == 4) begin
        mul_valid = 1'b1; mul_result = 64'hDEAD_BEEF_DEAD_BEEF;
        applyStimulus(4'b0011, 1'b0, 1'b1, 1'b1, 5'd30, 5'd31, 32'h5, 32'h6);
      end
      if (i == 5) begin div_valid = 1'b1; div_result = 64'h0000_0003_0000_0007; end
    end

    // ALU0 on way0, MUL on way1 with way1 empty; early DIV pulse is not pending
    k = cyc;
    applyStimulus(4'b0101, 1'b1, 1'b1, 1'b0, 5'd7, 5'd8, 32'hAAAA, 32'hBBBB);
    pushExp(k + 4, 1, 0, 5'd7, 5'd8, 32'hAAAA, 32'd0, 0, 0, 0, 1, 64'd0, 64'h1234_5678_9ABC_DEF0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      idleInputs();
      checkOutput($sformatf("alu_mul_stall_%0d", i), {63'd0, stall_req}, (i <= 4) ? 64'd1 : 64'd0);
      if (i == 1) begin div_valid = 1'b1; div_result = 64'hFFFF_FFFF_FFFF_FFFF; end
      if (i == 3) begin mul_valid = 1'b1; mul_result = 64'h1234_5678_9ABC_DEF0; end
    end

    // Flush while DIV is pending: group discarded, later DIV pulse produces nothing
    applyStimulus(4'b1010, 1'b1, 1'b1, 1'b1, 5'd9, 5'd10, 32'h1, 32'h2);
    for (int i = 1; i <= 6; i++) begin
      tick();
      idleInputs();
      checkOutput($sformatf("flush_stall_%0d", i), {63'd0, stall_req}, (i <= 2) ? 64'd1 : 64'd0);
      if (i == 2) flush = 1'b1;
      if (i == 4) begin div_valid = 1'b1; div_result = 64'h5555_5555_5555_5555; end
    end

    // Illegal enable code behaves as an ALU pair and raises the error pulse
    k = cyc;
    applyStimulus(4'b0111, 1'b1, 1'b1, 1'b1, 5'd11, 5'd12, 32'h55, 32'h66);
    pushExp(k + 1, 1, 1, 5'd11, 5'd12, 32'h55, 32'h66, 0, 0, 0, 0, 64'd0, 64'd0);
    tick();
    idleInputs();
    checkOutput("illegal_err_pulse", {63'd0, fu_en_err}, 64'd1);
    checkOutput("illegal_stall", {63'd0, stall_req}, 64'd1);
    tick();
    checkOutput("illegal_err_clear", {63'd0, fu_en_err}, 64'd0);
    checkOutput("illegal_stall_end", {63'd0, stall_req}, 64'd0);

    // Flush together with issue in IDLE: issue is dropped
    applyStimulus(4'b0011, 1'b0, 1'b1, 1'b1, 5'd20, 5'd21, 32'h9, 32'hA);
    flush = 1'b1;
    tick();
    idleInputs();
    checkOutput("flush_issue_stall", {63'd0, stall_req}, 64'd0);
    checkOutput("flush_issue_err", {63'd0, fu_en_err}, 64'd0);
    tick();

    // Both long units complete in the same cycle with swapped mapping
    k = cyc;
    applyStimulus(4'b1100, 1'b1, 1'b1, 1'b1, 5'd15, 5'd16, 32'h0, 32'h0);
    pushExp(k + 2, 1, 1, 5'd15, 5'd16, 32'd0, 32'd0, 1, 1, 1, 1,
            64'h0000_0001_0000_0002, 64'h0000_0010_0000_0020);
    tick();
    idleInputs();
    mul_valid = 1'b1; mul_result = 64'h0000_0010_0000_0020;
    div_valid = 1'b1; div_result = 64'h0000_0001_0000_0002;
    tick();
    idleInputs();
    checkOutput("both_pulse_stall", {63'd0, stall_req}, 64'd1);
    tick();
    checkOutput("both_pulse_stall_end", {63'd0, stall_req}, 64'd0);

    // MUL on way0 with ALU1 on way1
    k = cyc;
    applyStimulus(4'b0110, 1'b0, 1'b1, 1'b1, 5'd17, 5'd18, 32'hDEAD, 32'hBEEF);
    pushExp(k + 2, 1, 1, 5'd17, 5'd18, 32'd0, 32'hBEEF, 1, 0, 1, 0, 64'h0000_0042_0000_0099, 64'd0);
    tick();
    idleInputs();
    mul_valid = 1'b1; mul_result = 64'h0000_0042_0000_0099;
    tick();
    idleInputs();
    tick();

    // Reset while waiting on DIV clears everything at once; the later pulse is ignored
    applyStimulus(4'b1001, 1'b0, 1'b1, 1'b1, 5'd13, 5'd14, 32'h99, 32'hAA);
    tick();
    idleInputs();
    checkOutput("pre_reset_stall", {63'd0, stall_req}, 64'd1);
    tick();
    reset = 1'b1;
    #1;
    checkAllZero("mid_wait_reset");
    reset = 1'b0;
    tick();
    div_valid = 1'b1; div_result = 64'h7777_7777_7777_7777;
    tick();
    idleInputs();
    checkOutput("post_reset_stall", {63'd0, stall_req}, 64'd0);
    tick();
    tick();

    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fu_result_collector.md
FU_RESULT_COLLECTOR -- requirements
Module: fu_result_collector

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-002 flush  in  1  discard the in-flight issue group.
REQ-003 issue_valid  in  1  issue group present this cycle.
REQ-004 FU_en  in  4  unit enables: bit0 ALU0, bit1 ALU1, bit2 MUL, bit3 DIV.
REQ-005 FU_ctrl  in  1  0: way0=ALU0|MUL, way1=ALU1|DIV; 1: way0=ALU0|DIV, way1=ALU1|MUL.
REQ-006 way0_valid, way1_valid  in  1 each  way carries a real instruction.
REQ-007 way0_waddr, way1_waddr  in  5 each  destination GPR per way.
REQ-008 alu0_result, alu1_result  in  32 each  ALU results, valid in the issue cycle.
REQ-009 mul_valid  in  1; mul_result  in  64  one-cycle MUL completion pulse and {HI,LO}.
REQ-010 div_valid  in  1; div_result  in  64  one-cycle DIV completion pulse and {remainder,quotient}.
REQ-011 wb0_valid, wb1_valid  out  1 each  writeback strobe per way.
REQ-012 wb0_waddr, wb1_waddr  out  5 each; wb0_data, wb1_data  out  32 each  GPR writeback.
REQ-013 wb0_hilo_we, wb1_hilo_we  out  1 each; wb0_hilo, wb1_hilo  out  64 each  HI/LO writeback.
REQ-014 stall_req  out  1  upstream issue must hold.
REQ-015 fu_en_err  out  1  one-cycle pulse on an illegal FU_en code.

Function
REQ-016 Legal FU_en codes SHALL be 0011, 0101, 0110, 1001, 1010, 1100; any other code accepted SHALL be processed as 0011 with FU_ctrl=0 and SHALL pulse fu_en_err in the following cycle.
REQ-017 The FSM SHALL have states IDLE, WAIT, OUT; reset state IDLE.
REQ-018 In IDLE with issue_valid=1 the block SHALL latch FU_en, FU_ctrl, way valids, waddrs and the enabled ALU results, and SHALL set pending = FU_en[3:2].
REQ-019 IDLE SHALL transition to OUT if pending=00, otherwise to WAIT.
REQ-020 In WAIT, mul_valid SHALL latch mul_result and clear pending[0]; div_valid SHALL latch div_result and clear pending[1]; both in one cycle SHALL be legal.
REQ-021 WAIT SHALL transition to OUT in the cycle after pending reaches 00.
REQ-022 mul_valid/div_valid SHALL be ignored in IDLE and OUT, and for a unit not pending.
REQ-023 OUT SHALL last exactly one cycle, drive the wb outputs, and return to IDLE.
REQ-024 In OUT, wbN_valid SHALL equal the latched wayN_valid; all wb outputs SHALL be 0 in every other state.
REQ-025 A way mapped to an ALU SHALL drive wbN_data = ALU result and wbN_hilo_we=0; a way mapped to MUL/DIV SHALL drive wbN_hilo = unit result, wbN_hilo_we = wayN_valid, wbN_data = 0.
REQ-026 wbN_waddr SHALL equal the latched wayN_waddr in OUT.
REQ-027 Way-to-unit mapping SHALL follow FU_ctrl exactly as in REQ-005.
REQ-028 stall_req SHALL be 1 combinationally whenever state is not IDLE, and 0 in IDLE.
REQ-029 issue_valid outside IDLE SHALL be ignored.
REQ-030 Latency SHALL be 1 cycle from issue to OUT for ALU-only groups and 1 cycle from the last MUL/DIV pulse to OUT.
REQ-031 flush SHALL force IDLE in the next cycle, clear pending, suppress any OUT, and take priority over a simultaneous issue_valid or completion pulse.

Reset
REQ-032 Reset SHALL asynchronously force IDLE, pending=00, all latched data to 0, and all outputs (wb*, stall_req, fu_en_err) to 0.
REQ-033 Reset assertion mid-WAIT SHALL discard the group; later completion pulses SHALL produce no writeback.

Verification
REQ-034 FU_en=0011, ctrl=0, waddr 3/4, ALU results 0x11/0x22 -> next cycle wb0=(3,0x11), wb1=(4,0x22), both valid, stall_req high one cycle.
REQ-035 FU_en=1100, ctrl=0, mul pulse at +2, div pulse at +5 -> stall_req high 6 cycles; OUT at +6 with wb0_hilo=mul_result and wb1_hilo=div_result, both hilo_we=1.
REQ-036 FU_en=0101, ctrl=1, way1_valid=0, mul pulse at +3 -> OUT at +4, wb0_valid=1 with ALU0 data, wb1_valid=0, wb1_hilo_we=0.
REQ-037 FU_en=1010, ctrl=1, flush at +2 then div pulse at +4 -> IDLE at +3, no wb strobes, stall_req low from +3.
REQ-038 FU_en=0111 -> fu_en_err pulse next cycle; ALU0/ALU1 writeback as 0011 with ctrl=0.
REQ-039 Reset asserted in WAIT with FU_en=1001 -> all outputs 0 immediately; following div pulse ignored.
